// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - shared types and defaults for the Montgomery multiplier
package mont_pkg;

  localparam int N_W_DEFAULT = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mont_state_t;

endpackage

// File: rtl/mont_cond_sub.sv
// rtl/mont_cond_sub.sv - final conditional subtraction, brings m from [0, 2n) into [0, n)
module mont_cond_sub
  import mont_pkg::*;
#(
  parameter int N_W = N_W_DEFAULT
) (
  input  logic [N_W+1:0] m_i,
  input  logic [N_W-1:0] n_i,
  output logic [N_W-1:0] r_o
);

  logic [N_W+1:0] n_ext;
  logic [N_W-1:0] diff;

  assign n_ext = {2'b00, n_i};
  // m < 2n always holds, so m - n fits in N_W bits and the low bits suffice
  assign diff  = m_i[N_W-1:0] - n_i;
  assign r_o   = (m_i >= n_ext) ? diff : m_i[N_W-1:0];

endmodule

// File: rtl/mont_mul_param.sv
// rtl/mont_mul_param.sv - bit-serial Montgomery multiplier, result = a*b*2^-N_W mod n
module mont_mul_param
  import mont_pkg::*;
#(
  parameter int N_W = N_W_DEFAULT
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [N_W-1:0] i_n,
  input  logic [N_W-1:0] i_a,
  input  logic [N_W-1:0] i_b,
  input  logic           i_square,
  output logic           o_busy,
  output logic [N_W-1:0] o_result,
  output logic           o_end,
  output logic           o_err
);

  localparam int IDX_W = $clog2(N_W);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_W - 1);

  mont_state_t    state_q, state_d;
  logic [N_W-1:0] n_q, n_d;
  logic [N_W-1:0] a_q, a_d;
  logic [N_W-1:0] b_q, b_d;
  logic [N_W+1:0] m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_W-1:0] result_q, result_d;
  logic           err_q, err_d;

  logic           a_bit;
  logic [N_W+1:0] sum;
  logic [N_W-1:0] fix_val;

  assign a_bit = a_q[cnt_q[IDX_W-1:0]];

  mont_cond_sub #(.N_W(N_W)) u_cond_sub (
    .m_i (m_q),
    .n_i (n_q),
    .r_o (fix_val)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    sum      = '0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          result_d = '0;
          err_d    = 1'b0;
          m_d      = '0;
          cnt_d    = '0;
          if (i_n[0]) begin
            n_d     = i_n;
            a_d     = i_a;
            b_d     = i_square ? i_a : i_b;
            state_d = CALC;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        // m stays below 2n, so m + b + n < 4n never overflows N_W+2 bits
        sum = m_q + (a_bit ? {2'b00, b_q} : '0);
        if (sum[0]) begin
          sum = sum + {2'b00, n_q};
        end
        m_d   = sum >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
        end
      end
      FIX: begin
        result_d = fix_val;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_busy   = (state_q == CALC) || (state_q == FIX);
  assign o_end    = (state_q == DONE);
  assign o_err    = err_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_mont_mul_param.sv
// tb/tb_mont_mul_param.sv - self-checking bench for mont_mul_param at N_W=8 and N_W=256
module tb_mont_mul_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, start8, sq8, busy8, end8, err8;
  logic [7:0] n8, a8, b8, res8;

  logic         rst256, start256, sq256, busy256, end256, err256;
  logic [255:0] n256, a256, b256, res256;

  mont_mul_param #(.N_W(8)) dut8 (
    .i_clk(clk), .i_rst(rst8), .i_start(start8), .i_n(n8), .i_a(a8), .i_b(b8),
    .i_square(sq8), .o_busy(busy8), .o_result(res8), .o_end(end8), .o_err(err8)
  );

  mont_mul_param #(.N_W(256)) dut256 (
    .i_clk(clk), .i_rst(rst256), .i_start(start256), .i_n(n256), .i_a(a256), .i_b(b256),
    .i_square(sq256), .o_busy(busy256), .o_result(res256), .o_end(end256), .o_err(err256)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] n;
    logic [7:0] a;
    logic [7:0] b;
    logic       sq;
    logic [7:0] res;
    logic       err;
  } vec_t;

  vec_t vecs[10];

  // Call just after a posedge; counts further posedges until o_end is seen.
  task automatic wait_end8(inout int lat);
    logic seen;
    seen = 1'b0;
    while (!seen && lat < 400) begin
      @(negedge clk);
      start8 = 1'b0;
      if (end8) seen = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
  endtask

  task automatic run8(input logic [7:0] n, input logic [7:0] a, input logic [7:0] b,
                      input logic sq, output logic [7:0] res, output logic err,
                      output int lat, output logic busy1);
    @(negedge clk);
    n8 = n; a8 = a; b8 = b; sq8 = sq; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    busy1 = busy8;
    lat = 0;
    if (end8) begin
      start8 = 1'b0;
    end else begin
      @(posedge clk);
      lat = 1;
      wait_end8(lat);
    end
    res = res8;
    err = err8;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // r is the unique value below n with r*2^256 == a*b (mod n)
  function automatic logic ok256(input logic [255:0] r, input logic [255:0] n,
                                 input logic [255:0] a, input logic [255:0] b);
    logic [767:0] nn, lhs, rhs;
    nn  = {512'b0, n};
    lhs = ({512'b0, r} << 256) % nn;
    rhs = ({512'b0, a} * {512'b0, b}) % nn;
    return (r < n) && (lhs == rhs);
  endfunction

  initial begin
    logic [7:0]   r;
    logic         e, b1, seen;
    int           lat;
    logic [255:0] nr[3], ar[3], br[3];

    vecs[0] = '{n: 8'd13,  a: 8'd5,   b: 8'd7,   sq: 1'b0, res: 8'd1,  err: 1'b0};
    vecs[1] = '{n: 8'd255, a: 8'd254, b: 8'd0,   sq: 1'b1, res: 8'd1,  err: 1'b0};
    vecs[2] = '{n: 8'd13,  a: 8'd1,   b: 8'd1,   sq: 1'b0, res: 8'd3,  err: 1'b0};
    vecs[3] = '{n: 8'd12,  a: 8'd5,   b: 8'd7,   sq: 1'b0, res: 8'd0,  err: 1'b1};
    vecs[4] = '{n: 8'd13,  a: 8'd12,  b: 8'd12,  sq: 1'b0, res: 8'd3,  err: 1'b0};
    vecs[5] = '{n: 8'd251, a: 8'd10,  b: 8'd20,  sq: 1'b0, res: 8'd40, err: 1'b0};
    vecs[6] = '{n: 8'd254, a: 8'd1,   b: 8'd1,   sq: 1'b0, res: 8'd0,  err: 1'b1};
    vecs[7] = '{n: 8'd255, a: 8'd2,   b: 8'd3,   sq: 1'b0, res: 8'd6,  err: 1'b0};
    vecs[8] = '{n: 8'd13,  a: 8'd5,   b: 8'd9,   sq: 1'b1, res: 8'd10, err: 1'b0};
    vecs[9] = '{n: 8'd3,   a: 8'd2,   b: 8'd2,   sq: 1'b0, res: 8'd1,  err: 1'b0};

    rst8 = 1'b1; start8 = 1'b0; sq8 = 1'b0; n8 = '0; a8 = '0; b8 = '0;
    rst256 = 1'b1; start256 = 1'b0; sq256 = 1'b0; n256 = '0; a256 = '0; b256 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", longint'(busy8), 0);
    chk("rst_end", longint'(end8), 0);
    chk("rst_err", longint'(err8), 0);
    chk("rst_result", longint'(res8), 0);
    chk("rst256_busy", longint'(busy256), 0);
    rst8 = 1'b0; rst256 = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run8(vecs[i].n, vecs[i].a, vecs[i].b, vecs[i].sq, r, e, lat, b1);
      chk($sformatf("vec%0d_result", i), longint'(r), longint'(vecs[i].res));
      chk($sformatf("vec%0d_err", i), longint'(e), longint'(vecs[i].err));
      chk($sformatf("vec%0d_latency", i), longint'(lat), vecs[i].err ? 0 : 9);
      chk($sformatf("vec%0d_busy", i), longint'(b1), vecs[i].err ? 0 : 1);
    end

    // start pulse with a=0 on edge k+3 must not disturb the running operation
    @(negedge clk);
    n8 = 8'd13; a8 = 8'd5; b8 = 8'd7; sq8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    a8 = 8'd0; start8 = 1'b1;
    @(posedge clk);
    lat = 3;
    wait_end8(lat);
    chk("ignore_result", longint'(res8), 1);
    chk("ignore_latency", longint'(lat), 9);
    run8(8'd13, 8'd0, 8'd7, 1'b0, r, e, lat, b1);
    chk("zero_a_result", longint'(r), 0);

    // reset mid-CALC after a nonzero result
    run8(8'd13, 8'd5, 8'd7, 1'b0, r, e, lat, b1);
    chk("pre_reset_result", longint'(r), 1);
    @(negedge clk);
    n8 = 8'd13; a8 = 8'd1; b8 = 8'd1; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst8 = 1'b1;
    #1;
    chk("midrst_busy", longint'(busy8), 0);
    chk("midrst_end", longint'(end8), 0);
    chk("midrst_err", longint'(err8), 0);
    chk("midrst_result", longint'(res8), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst8 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (end8 || busy8) seen = 1'b1;
    end
    chk("midrst_no_end", longint'(seen), 0);
    run8(8'd13, 8'd1, 8'd1, 1'b0, r, e, lat, b1);
    chk("restart_result", longint'(r), 3);
    chk("restart_latency", longint'(lat), 9);

    // N_W=256 back-to-back with i_start held high
    for (int j = 0; j < 3; j++) begin
      nr[j] = rand256();
      nr[j][255] = 1'b1;
      nr[j][0] = 1'b1;
      ar[j] = rand256() % nr[j];
      br[j] = rand256() % nr[j];
    end
    @(negedge clk);
    n256 = nr[0]; a256 = ar[0]; b256 = br[0]; start256 = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("w%0d_busy", j), longint'(busy256), 1);
      n256 = '1; a256 = '0; b256 = '0;
      lat = 0;
      seen = 1'b0;
      while (!seen && lat < 600) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
        if (end256) seen = 1'b1;
      end
      chk($sformatf("w%0d_latency", j), longint'(lat), 257);
      chk($sformatf("w%0d_result_ok", j), longint'(ok256(res256, nr[j], ar[j], br[j])), 1);
      chk($sformatf("w%0d_err", j), longint'(err256), 0);
      if (j < 2) begin
        n256 = nr[j+1]; a256 = ar[j+1]; b256 = br[j+1];
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("w%0d_idle_busy", j), longint'(busy256), 0);
        chk($sformatf("w%0d_idle_end", j), longint'(end256), 0);
        @(posedge clk);
      end else begin
        start256 = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
